ones_pattern_gen: RTL and testbench
===================================

Name: ones_pattern_gen

Overview:
- Inverse of the 127-bit ones counter: takes a 7-bit ones count and produces a 127-bit thermometer word with exactly that many ones, packed from bit 0 upward.
- The word is built sequentially, CHUNK bits per cycle, so the logic stays small.
- Valid/ready handshakes on input and output.
- Used to generate popcount stimulus and reference patterns feeding the counter datapath.

Parameters:
- N, 127, output vector width in bits.
- W, 7, count width; must satisfy 2^W > N.
- CHUNK, 8, bits filled per cycle; NCH = ceil(N/CHUNK) = 16 chunks.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  count is presented
- in_ready  out  1  block can accept a count
- count  in  W  requested number of ones
- out_valid  out  1  pattern complete and stable
- out_ready  in  1  consumer accepts pattern
- pattern  out  N  thermometer word; pattern[k] = 1 iff k < min(count, N)
- sat  out  1  latched count exceeded N, so the result is saturated to all ones

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high.
- Reset (async, any state, including mid-fill) sets:
  - state=IDLE, pattern=0, sat=0, out_valid=0, chunk index=0, latched count=0.
  - in_ready=1 once rst deasserts.
- FSM states: IDLE, FILL, HOLD.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch count, clear pattern to 0, set sat=(count>N), idx=0, go to FILL.
- FILL:
  - in_ready=0, out_valid=0.
  - Each cycle, write pattern[idx*CHUNK +: CHUNK], bit j = ((idx*CHUNK+j) < count_latched). Positions >= N are not written.
  - Then idx++. On the cycle idx==NCH-1 is written, go to HOLD.
  - in_valid changes during FILL are ignored.
- HOLD:
  - out_valid=1; pattern and sat held stable.
  - On out_ready: go to IDLE, out_valid drops next cycle. pattern and sat keep their value until the next accept.
  - Without out_ready: stay in HOLD indefinitely.
- Latency:
  - Fixed, independent of count value.
  - Accept at edge E; out_valid high after edge E+NCH (16 cycles with defaults).
- Throughput:
  - Minimum NCH+2 cycles per pattern.
  - in_ready is only high in IDLE; there is no same-cycle accept in HOLD.
- Arithmetic: compare in W+1 bits so N and the count never overflow. With defaults, count=127 gives all ones and sat=0.
- Invariants at out_valid:
  - popcount(pattern)==min(count,N).
  - pattern is contiguous ones from LSB.
  - Feeding pattern to the ones counter returns min(count,N).
- pattern is meaningful only while out_valid=1. Partial values are visible during FILL.

Test Plan:
- Reset, then count=0 with in_valid -> in_ready drops; out_valid rises exactly 16 cycles after accept; pattern=0, sat=0.
- count=127 -> pattern all ones (127'h7FFF...F), sat=0; ones counter on pattern returns 127.
- Chunk boundaries:
  - count=8 -> pattern=127'hFF.
  - count=9 -> pattern=127'h1FF.
  - count=1 -> 127'h1.
  - count=64 -> bits [63:0] set, bits [126:64] clear.
- Backpressure: out_ready held low 20 cycles in HOLD -> out_valid stays 1, pattern stable, in_ready=0. Pulse out_ready -> IDLE next cycle; a new count=5 is accepted and yields 127'h1F.
- Async rst pulse mid-FILL (idx=7, count=100) -> outputs clear immediately without a clock edge; next request count=3 yields 127'h7 with correct 16-cycle latency.
- Random sweep of all counts 0..127, back-to-back, with random out_ready stalls -> every result satisfies the thermometer and popcount invariants.

Source files
------------

// File: rtl/ones_pattern_gen.sv
// rtl/ones_pattern_gen.sv - ones count to thermometer word, filled CHUNK bits per cycle
module ones_pattern_gen #(
  parameter int N     = 127,
  parameter int W     = 7,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] count,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pattern,
  output logic         sat
);

  localparam int NCH  = (N + CHUNK - 1) / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IDXW-1:0] idx;
  logic [W-1:0]    count_l;
  logic            accept;
  logic            last_chunk;

  assign accept     = in_valid && in_ready;
  assign last_chunk = (idx == IDXW'(NCH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) state_nxt = FILL;
      end
      FILL: begin
        if (last_chunk) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Compares run in W+1 bits so N itself and the largest count never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern <= '0;
      sat     <= 1'b0;
      idx     <= '0;
      count_l <= '0;
    end else if (accept) begin
      count_l <= count;
      pattern <= '0;
      sat     <= ({1'b0, count} > (W+1)'(N));
      idx     <= '0;
    end else if (state == FILL) begin
      for (int k = 0; k < N; k++) begin
        if (idx == IDXW'(k / CHUNK))
          pattern[k] <= ({1'b0, count_l} > (W+1)'(k));
      end
      idx <= last_chunk ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_ones_pattern_gen.sv
// tb/tb_ones_pattern_gen.sv - directed table plus corner sequences for ones_pattern_gen
`timescale 1ns/100ps
module tb_ones_pattern_gen;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [6:0]   count = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [126:0] pattern;
  logic         sat;

  int checks = 0;
  int failures = 0;

  ones_pattern_gen dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .count(count),
    .out_valid(out_valid), .out_ready(out_ready), .pattern(pattern), .sat(sat)
  );

  always #10 clk = ~clk;

  typedef struct {
    string        name;
    logic [6:0]   c;
    logic [126:0] p;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [126:0] act, input logic [126:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [126:0] therm(input int c);
    logic [126:0] p;
    for (int i = 0; i < 127; i++) p[i] = (i < c);
    return p;
  endfunction

  // Entered and left at #1 after a rising edge.
  task automatic run_one(input string name, input logic [6:0] c, input logic [126:0] exp_pat, input int stall);
    int n;
    logic [126:0] first;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({name, "_in_ready"}, 127'(in_ready), 127'd1);
    in_valid = 1'b1;
    count    = c;
    @(posedge clk); #1;
    chk({name, "_busy"}, 127'(in_ready), 127'd0);
    count = ~c;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
      if (n == 4) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk({name, "_latency"}, 127'(n), 127'd16);
    chk({name, "_pattern"}, pattern, exp_pat);
    chk({name, "_sat"}, 127'(sat), 127'd0);
    chk({name, "_popcount"}, 127'($countones(pattern)), 127'(c));
    chk({name, "_contig"}, pattern & (pattern + 127'd1), 127'd0);
    first = pattern;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk({name, "_hold_valid"}, 127'(out_valid), 127'd1);
      chk({name, "_hold_stable"}, pattern, first);
      chk({name, "_hold_noready"}, 127'(in_ready), 127'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_drop_valid"}, 127'(out_valid), 127'd0);
    chk({name, "_back_idle"}, 127'(in_ready), 127'd1);
  endtask

  initial begin
    tbl[0] = '{"c0",   7'd0,   127'h0};
    tbl[1] = '{"c127", 7'd127, {127{1'b1}}};
    tbl[2] = '{"c8",   7'd8,   127'hFF};
    tbl[3] = '{"c9",   7'd9,   127'h1FF};
    tbl[4] = '{"c1",   7'd1,   127'h1};
    tbl[5] = '{"c64",  7'd64,  {63'h0, {64{1'b1}}}};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pattern", pattern, 127'd0);
    chk("rst_valid", 127'(out_valid), 127'd0);
    chk("rst_sat", 127'(sat), 127'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 127'(in_ready), 127'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_one(tbl[i].name, tbl[i].c, tbl[i].p, 0);

    run_one("bp_c5_prev", 7'd20, therm(20), 20);
    run_one("bp_c5", 7'd5, 127'h1F, 0);

    // Async reset while idx==7 of a count=100 fill
    in_valid = 1'b1;
    count    = 7'd100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("midfill_partial", pattern, therm(56));
    #1 rst = 1'b1;
    #1;
    chk("arst_pattern", pattern, 127'd0);
    chk("arst_valid", 127'(out_valid), 127'd0);
    chk("arst_sat", 127'(sat), 127'd0);
    #1 rst = 1'b0;
    #1;
    chk("arst_in_ready", 127'(in_ready), 127'd1);
    @(posedge clk); #1;
    run_one("after_rst_c3", 7'd3, 127'h7, 0);

    for (int c = 0; c < 128; c++) run_one($sformatf("sweep%0d", c), 7'(c), therm(c), $urandom_range(0, 3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
